y86_decode_regfile: RTL

Parametrised decode stage with an integrated register file for the sequential and pipelined Y86-64 cores. It sits between fetch and execute: it accepts a fetched instruction (icode, rA, rB) over a valid/ready handshake, derives the source and destination register IDs, reads operands with same-cycle writeback bypass, and presents them in a registered output slot. It also owns the architectural register state, updated through two writeback ports (E and M).

---
 rtl/y86_decode_regfile_if.sv | 30 +++
 rtl/y86_decode_regfile.sv | 131 +++++++++++++
 2 files changed

// File: rtl/y86_decode_regfile_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for y86_decode_regfile.
interface y86_decode_regfile_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_icode;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic              out_err;

  modport master (
    output in_valid, icode, rA, rB, out_ready,
    input  in_ready, out_valid, out_icode, srcA, srcB, dstE, dstM, valA, valB, out_err
  );

  modport slave (
    input  in_valid, icode, rA, rB, out_ready,
    output in_ready, out_valid, out_icode, srcA, srcB, dstE, dstM, valA, valB, out_err
  );
endinterface

// File: rtl/y86_decode_regfile.sv
// Y86-64 decode stage: register ID derivation, bypassed operand read,
// registered output slot, and the architectural register file with E/M writeback.
module y86_decode_regfile #(
  parameter int                 DATA_W   = 64,
  parameter int                 NUM_REGS = 15,
  parameter logic [3:0]         RSP_ID   = 4'd4,
  parameter logic [DATA_W-1:0]  RSP_INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  y86_decode_regfile_if.slave   bus,
  input  logic                  wE_en,
  input  logic                  wM_en,
  input  logic [3:0]            wE_dst,
  input  logic [3:0]            wM_dst,
  input  logic [DATA_W-1:0]     wE_val,
  input  logic [DATA_W-1:0]     wM_val,
  input  logic [3:0]            dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  typedef enum logic [3:0] {
    I_HALT  = 4'h0,
    I_NOP   = 4'h1,
    I_CMOV  = 4'h2,
    I_IRMOV = 4'h3,
    I_RMMOV = 4'h4,
    I_MRMOV = 4'h5,
    I_OPQ   = 4'h6,
    I_JXX   = 4'h7,
    I_CALL  = 4'h8,
    I_RET   = 4'h9,
    I_PUSH  = 4'hA,
    I_POP   = 4'hB
  } icode_t;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  // Sized to the full 4-bit ID space so any ID indexes cleanly; entries at or
  // above NUM_REGS are never written and never read.
  logic [DATA_W-1:0] regs [16];

  logic [3:0]        dec_srcA, dec_srcB, dec_dstE, dec_dstM;
  logic [DATA_W-1:0] dec_valA, dec_valB;
  logic              dec_err;
  logic              load;

  function automatic logic in_range(input logic [3:0] id);
    return (id != RNONE) && ({1'b0, id} < NREGS);
  endfunction

  function automatic logic bad_id(input logic [3:0] id);
    return (id != RNONE) && !in_range(id);
  endfunction

  // Post-writeback view of a source register: M beats E beats stored value.
  function automatic logic [DATA_W-1:0] read_op(input logic [3:0] id);
    if (!in_range(id))               return '0;
    if (wM_en && (wM_dst == id))     return wM_val;
    if (wE_en && (wE_dst == id))     return wE_val;
    return regs[id];
  endfunction

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;
  assign dbg_data     = in_range(dbg_addr) ? regs[dbg_addr] : '0;

  // Derive register IDs from icode, then read operands through the bypass.
  always_comb begin
    dec_srcA = RNONE;
    dec_srcB = RNONE;
    dec_dstE = RNONE;
    dec_dstM = RNONE;
    case (icode_t'(bus.icode))
      I_CMOV:  begin dec_srcA = bus.rA;                         dec_dstE = bus.rB; end
      I_IRMOV: begin                                            dec_dstE = bus.rB; end
      I_RMMOV: begin dec_srcA = bus.rA; dec_srcB = bus.rB;                         end
      I_MRMOV: begin                    dec_srcB = bus.rB;      dec_dstM = bus.rA; end
      I_OPQ:   begin dec_srcA = bus.rA; dec_srcB = bus.rB;      dec_dstE = bus.rB; end
      I_CALL:  begin                    dec_srcB = RSP_ID;      dec_dstE = RSP_ID; end
      I_RET:   begin dec_srcA = RSP_ID; dec_srcB = RSP_ID;      dec_dstE = RSP_ID; end
      I_PUSH:  begin dec_srcA = bus.rA; dec_srcB = RSP_ID;      dec_dstE = RSP_ID; end
      I_POP:   begin dec_srcA = RSP_ID; dec_srcB = RSP_ID;      dec_dstE = RSP_ID;
                     dec_dstM = bus.rA; end
      default: ;
    endcase
    dec_valA = read_op(dec_srcA);
    dec_valB = read_op(dec_srcB);
    dec_err  = bad_id(dec_srcA) || bad_id(dec_srcB) || bad_id(dec_dstE) || bad_id(dec_dstM);
  end

  // Register file: E then M so M wins on a shared destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++)
        regs[4'(i)] <= (4'(i) == RSP_ID) ? RSP_INIT : '0;
    end else begin
      if (wE_en && in_range(wE_dst)) regs[wE_dst] <= wE_val;
      if (wM_en && in_range(wM_dst)) regs[wM_dst] <= wM_val;
    end
  end

  // Output slot: load on accept, clear on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_icode <= '0;
      bus.srcA      <= '0;
      bus.srcB      <= '0;
      bus.dstE      <= '0;
      bus.dstM      <= '0;
      bus.valA      <= '0;
      bus.valB      <= '0;
      bus.out_err   <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_icode <= bus.icode;
      bus.srcA      <= dec_srcA;
      bus.srcB      <= dec_srcB;
      bus.dstE      <= dec_dstE;
      bus.dstM      <= dec_dstM;
      bus.valA      <= dec_valA;
      bus.valB      <= dec_valB;
      bus.out_err   <= dec_err;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
